datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port control, input, 16 bits: control word from the control unit, sampled at each rising clk edge.
REQ-004 The block SHALL have the port data_in, input, 4 bits: external operand input.
REQ-005 The block SHALL have the ports A_out and B_out, output, 4 bits each: registers A and B.
REQ-006 The block SHALL have the port out_port, output, 4 bits: registered output port.
REQ-007 The block SHALL have the port bus_out, output, 4 bits: combinational internal bus value.
REQ-008 The block SHALL have the ports zero and carry, output, 1 bit each: registered ALU flags.
REQ-009 The block SHALL have the port halted, output, 1 bit: high while in HALTED state.
REQ-010 The block SHALL have the port step_count, output, 8 bits: count of cycles with at least one register load performed.

Function
REQ-011 The block SHALL decode the control field map as: [15]=LA (load A from bus), [14]=LB (load B from bus), [13]=LO (load out_port from bus), [12:11]=bus source, [10:8]=ALU op, [7]=LF (load flags), [6]=CLR, [5]=HALT; bits [4:0] are reserved and ignored.
REQ-012 The block SHALL drive the bus source combinationally: 00=data_in, 01=A, 10=B, 11=ALU result.
REQ-013 The block SHALL compute ALU ops on current A,B: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A+1, 111 A-1; result = low 4 bits.
REQ-014 The block SHALL compute carry as: ADD/INC = bit 4 of the 5-bit sum; SUB/DEC = borrow (1 when A<B, or A==0 for DEC); logic ops = 0.
REQ-015 The block SHALL compute zero as 1 iff the 4-bit ALU result equals 0.
REQ-016 The block SHALL update flags only on an edge with LF=1; otherwise flags hold.
REQ-017 The block SHALL latch loads at the same edge with one-cycle latency; all loads in one cycle SHALL use pre-edge values (LA=LB=1 with bus=A: B gets old A, A unchanged).
REQ-018 The block SHALL implement two states, RUN and HALTED; reset enters RUN.
REQ-019 In RUN, HALT=1 SHALL perform that cycle's loads/CLR and then enter HALTED at the same edge.
REQ-020 In HALTED, all registers, flags and step_count SHALL freeze, and control SHALL be ignored (including CLR); only reset exits.
REQ-021 In RUN, CLR=1 SHALL zero A, B, out_port, zero and carry at the edge, taking priority over LA/LB/LO/LF in the same cycle; step_count is unaffected.
REQ-022 step_count SHALL increment by 1 on each RUN edge where any of LA, LB, LO is 1 and CLR=0, and SHALL wrap from 255 to 0.
REQ-023 bus_out SHALL reflect the selected source in every state, including HALTED.

Reset
REQ-024 While reset=0, A, B, out_port, zero, carry and step_count SHALL be forced to 0, halted to 0, and the state to RUN, asynchronously and independently of clk.
REQ-025 Reset assertion mid-operation SHALL discard any in-flight load at that edge; the first update after release SHALL occur at the first rising edge with reset=1.

Verification
REQ-026 Load/add: data_in=5, LA src=00; data_in=3, LB src=00; src=11, op=000, LO, LF -> out_port=8, zero=0, carry=0, step_count=3.
REQ-027 Carry/wrap: A=F, B=1, op=000, LA, LF, src=11 -> A=0, zero=1, carry=1; then op=110 (INC) -> A=1, carry=0.
REQ-028 Borrow: A=2, B=3, op=001, LF, LO, src=11 -> out_port=F, carry=1, zero=0.
REQ-029 Priority: CLR=1 with LA=1, data_in=7 -> A=0, flags 0, step_count unchanged; then HALT=1 with LO, src=01 -> out_port loaded, halted=1; later LA/CLR words -> no change.
REQ-030 Async reset: assert reset=0 mid-clock with A=9, halted=1 -> all outputs 0 immediately, before the next edge; after release, the first load takes effect at the next edge.
REQ-031 Counter wrap: 256 consecutive LO cycles from reset -> step_count returns to 0.

Source files
------------

// File: rtl/datapath.sv
// 4-bit accumulator-style datapath: A/B/out registers, an 8-op ALU with registered flags,
// a shared source bus, and a RUN/HALTED controller with a load-step counter.
module datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] control,
    input  logic [3:0]  data_in,
    output logic [3:0]  A_out,
    output logic [3:0]  B_out,
    output logic [3:0]  out_port,
    output logic [3:0]  bus_out,
    output logic        zero,
    output logic        carry,
    output logic        halted,
    output logic [7:0]  step_count
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [3:0]  a_q, a_d, b_q, b_d, o_q, o_d;
    logic        z_q, z_d, c_q, c_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        ld_a, ld_b, ld_o, ld_f, clr, hlt;
    logic [1:0]  src;
    logic [2:0]  op;
    logic [4:0]  alu_wide;
    logic [3:0]  alu_res;
    logic        alu_carry;
    logic [3:0]  bus;
    logic        unused_ctrl;

    assign ld_a        = control[15];
    assign ld_b        = control[14];
    assign ld_o        = control[13];
    assign src         = control[12:11];
    assign op          = control[10:8];
    assign ld_f        = control[7];
    assign clr         = control[6];
    assign hlt         = control[5];
    assign unused_ctrl = ^control[4:0];

    // Bit 4 of the widened result is the carry for add/inc and the borrow for sub/dec.
    always_comb begin
        alu_wide = 5'd0;
        unique case (op)
            3'b000:  alu_wide = {1'b0, a_q} + {1'b0, b_q};
            3'b001:  alu_wide = {1'b0, a_q} - {1'b0, b_q};
            3'b010:  alu_wide = {1'b0, a_q & b_q};
            3'b011:  alu_wide = {1'b0, a_q | b_q};
            3'b100:  alu_wide = {1'b0, a_q ^ b_q};
            3'b101:  alu_wide = {1'b0, ~a_q};
            3'b110:  alu_wide = {1'b0, a_q} + 5'd1;
            3'b111:  alu_wide = {1'b0, a_q} - 5'd1;
            default: alu_wide = 5'd0;
        endcase
    end

    assign alu_res   = alu_wide[3:0];
    assign alu_carry = alu_wide[4];

    always_comb begin
        bus = data_in;
        unique case (src)
            2'b00:   bus = data_in;
            2'b01:   bus = a_q;
            2'b10:   bus = b_q;
            2'b11:   bus = alu_res;
            default: bus = data_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        z_d     = z_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        if (state_q == StRun) begin
            if (clr) begin
                a_d = 4'd0;
                b_d = 4'd0;
                o_d = 4'd0;
                z_d = 1'b0;
                c_d = 1'b0;
            end else begin
                if (ld_a) a_d = bus;
                if (ld_b) b_d = bus;
                if (ld_o) o_d = bus;
                if (ld_f) begin
                    z_d = (alu_res == 4'd0);
                    c_d = alu_carry;
                end
                if (ld_a || ld_b || ld_o) cnt_d = cnt_q + 8'd1;
            end
            if (hlt) state_d = StHalted;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            o_q     <= 4'd0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            z_q     <= z_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A_out      = a_q;
    assign B_out      = b_q;
    assign out_port   = o_q;
    assign bus_out    = bus;
    assign zero       = z_q;
    assign carry      = c_q;
    assign halted     = (state_q == StHalted);
    assign step_count = cnt_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: a driver pushes model predictions per cycle and a monitor
// compares them after each rising edge; async reset and halt behaviour are checked directly.
module tb_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] control;
    logic [3:0]  data_in;
    logic [3:0]  A_out, B_out, out_port, bus_out;
    logic        zero, carry, halted;
    logic [7:0]  step_count;

    datapath dut (
        .clk        (clk),
        .reset      (reset),
        .control    (control),
        .data_in    (data_in),
        .A_out      (A_out),
        .B_out      (B_out),
        .out_port   (out_port),
        .bus_out    (bus_out),
        .zero       (zero),
        .carry      (carry),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a, b, o, z, c, h, cnt;
    } model_t;

    typedef struct {
        int a, b, o, bus, z, c, h, cnt;
    } exp_t;

    model_t m;
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int la, input int lb, input int lo, input int src,
                                       input int op, input int lf, input int clr, input int hlt);
        logic [15:0] c;
        c = '0;
        c[15] = la[0];
        c[14] = lb[0];
        c[13] = lo[0];
        c[12:11] = src[1:0];
        c[10:8] = op[2:0];
        c[7] = lf[0];
        c[6] = clr[0];
        c[5] = hlt[0];
        return c;
    endfunction

    // ALU written as plain integer arithmetic; returns result and sets cy.
    function automatic int alu(input int a, input int b, input int op, output int cy);
        int r;
        cy = 0;
        case (op)
            0: begin r = a + b;      cy = (r > 15); end
            1: begin r = a - b + 16; cy = (a < b);  end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = a + 1;      cy = (r > 15); end
            default: begin r = a + 15; cy = (a == 0); end
        endcase
        return r % 16;
    endfunction

    function automatic int bus_of(input model_t s, input logic [15:0] c, input int d);
        int cy, src;
        src = int'(c[12:11]);
        case (src)
            0: return d;
            1: return s.a;
            2: return s.b;
            default: return alu(s.a, s.b, int'(c[10:8]), cy);
        endcase
    endfunction

    function automatic model_t step(input model_t s, input logic [15:0] c, input int d);
        model_t n;
        int res, cy, bus;
        n = s;
        if (s.h != 0) return n;
        res = alu(s.a, s.b, int'(c[10:8]), cy);
        bus = bus_of(s, c, d);
        if (c[6]) begin
            n.a = 0; n.b = 0; n.o = 0; n.z = 0; n.c = 0;
        end else begin
            if (c[15]) n.a = bus;
            if (c[14]) n.b = bus;
            if (c[13]) n.o = bus;
            if (c[7]) begin
                n.z = (res == 0);
                n.c = cy;
            end
            if (c[15] || c[14] || c[13]) n.cnt = (s.cnt + 1) % 256;
        end
        if (c[5]) n.h = 1;
        return n;
    endfunction

    function automatic model_t zero_model();
        model_t z;
        z.a = 0; z.b = 0; z.o = 0; z.z = 0; z.c = 0; z.h = 0; z.cnt = 0;
        return z;
    endfunction

    task automatic cycle(input logic [15:0] c, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        control = c;
        data_in = d;
        m = step(m, c, int'(d));
        e.a = m.a; e.b = m.b; e.o = m.o; e.z = m.z; e.c = m.c; e.h = m.h; e.cnt = m.cnt;
        e.bus = bus_of(m, c, int'(d));
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("A_out", 32'(A_out), e.a);
            check("B_out", 32'(B_out), e.b);
            check("out_port", 32'(out_port), e.o);
            check("bus_out", 32'(bus_out), e.bus);
            check("zero", 32'(zero), e.z);
            check("carry", 32'(carry), e.c);
            check("halted", 32'(halted), e.h);
            check("step_count", 32'(step_count), e.cnt);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"}, 32'(A_out), 0);
        check({tag, "_B"}, 32'(B_out), 0);
        check({tag, "_out"}, 32'(out_port), 0);
        check({tag, "_zero"}, 32'(zero), 0);
        check({tag, "_carry"}, 32'(carry), 0);
        check({tag, "_halted"}, 32'(halted), 0);
        check({tag, "_count"}, 32'(step_count), 0);
    endtask

    task automatic apply_reset(input string tag);
        drain();
        @(negedge clk);
        control = '0;
        reset   = 1'b0;
        #1;
        check_all_zero(tag);
        m = zero_model();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] c;
        reset   = 1'b0;
        control = '0;
        data_in = '0;
        m       = zero_model();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Load/add
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd5);
        cycle(mk(0, 1, 0, 0, 0, 0, 0, 0), 4'd3);
        cycle(mk(0, 0, 1, 3, 0, 1, 0, 0), 4'd0);
        drain();
        check("add_out", 32'(out_port), 8);
        check("add_count", 32'(step_count), 3);
        check("add_zero", 32'(zero), 0);

        // Carry/wrap then increment
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'hF);
        cycle(mk(0, 1, 0, 0, 0, 0, 0, 0), 4'h1);
        cycle(mk(1, 0, 0, 3, 0, 1, 0, 0), 4'h0);
        drain();
        check("wrap_A", 32'(A_out), 0);
        check("wrap_zero", 32'(zero), 1);
        check("wrap_carry", 32'(carry), 1);
        cycle(mk(1, 0, 0, 3, 6, 1, 0, 0), 4'h0);
        drain();
        check("inc_A", 32'(A_out), 1);
        check("inc_carry", 32'(carry), 0);

        // Borrow
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd2);
        cycle(mk(0, 1, 0, 0, 0, 0, 0, 0), 4'd3);
        cycle(mk(0, 0, 1, 3, 1, 1, 0, 0), 4'd0);
        drain();
        check("borrow_out", 32'(out_port), 15);
        check("borrow_carry", 32'(carry), 1);

        // Simultaneous loads use pre-edge values
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd6);
        cycle(mk(1, 1, 0, 1, 0, 0, 0, 0), 4'd0);
        cycle(mk(1, 1, 0, 3, 6, 0, 0, 0), 4'd0);

        // Randomised RUN traffic, no HALT, occasional CLR
        for (int i = 0; i < 300; i++) begin
            c = 16'($urandom);
            c[5] = 1'b0;
            if ($urandom_range(0, 7) != 0) c[6] = 1'b0;
            cycle(c, 4'($urandom));
        end
        drain();

        // CLR priority, then HALT, then frozen
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd4);
        cycle(mk(1, 1, 1, 0, 0, 1, 1, 0), 4'd7);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd9);
        cycle(mk(0, 0, 1, 1, 0, 0, 0, 1), 4'd2);
        drain();
        check("halt_out", 32'(out_port), 9);
        check("halt_flag", 32'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            c = 16'($urandom);
            if (i % 4 == 0) c = mk(1, 1, 1, 0, 0, 1, 1, 0);
            cycle(c, 4'($urandom));
        end
        drain();
        check("frozen_A", 32'(A_out), 9);
        check("frozen_halted", 32'(halted), 1);

        // Async reset mid-cycle; load during reset discarded; first load after release
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        m = zero_model();
        @(negedge clk);
        control = mk(1, 0, 0, 0, 0, 0, 0, 0);
        data_in = 4'd6;
        @(posedge clk);
        #1;
        check("inflight_A", 32'(A_out), 0);
        @(negedge clk);
        control = '0;
        reset   = 1'b1;
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0), 4'd6);
        drain();
        check("post_reset_A", 32'(A_out), 6);

        // Counter wrap
        apply_reset("wrap_reset");
        for (int i = 0; i < 256; i++) cycle(mk(0, 0, 1, 0, 0, 0, 0, 0), 4'($urandom));
        drain();
        check("count_wrap", 32'(step_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
